// File: rtl/koa_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : koa_share_ctrl
//  Description : Two-requester arbiter/controller in front of one shared,
//                fixed-latency Karatsuba multiplier. Serves one transaction at
//                a time. Ties alternate between requesters, and each product
//                is held in a register until its owner consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module koa_share_ctrl #(
    parameter int SW  = 24,     // operand width, at least 8
    parameter int LAT = 2       // multiplier latency in cycles, at least 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [SW-1:0]     req0_a_i,
    input  logic [SW-1:0]     req0_b_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [SW-1:0]     req1_a_i,
    input  logic [SW-1:0]     req1_b_i,

    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [2*SW-1:0]   result_o,

    output logic [SW-1:0]     mult_a_o,
    output logic [SW-1:0]     mult_b_o,
    input  logic [2*SW-1:0]   mult_p_i,

    output logic              busy_o
);

    // One extra counter bit, so counting up to LAT-1 can never wrap.
    localparam int            CW     = $clog2(LAT) + 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   op_a;
    logic [SW-1:0]   op_b;
    logic [2*SW-1:0] result;
    logic            owner;
    logic            last_grant;

    logic            win0;
    logic            win1;
    logic            take0;
    logic            take1;
    logic            owner_ready;

    // Arbitration: a lone requester wins. On a tie, the requester that was
    // not granted last wins.
    always_comb begin
        win0 = req0_valid_i & (~req1_valid_i | last_grant);
        win1 = req1_valid_i & (~req0_valid_i | ~last_grant);
    end

    // Grants are combinational and only given in IDLE. They are gated by rst
    // because IDLE is also the state forced while reset is held.
    assign req0_ready_o = (state == IDLE) & ~rst & win0;
    assign req1_ready_o = (state == IDLE) & ~rst & win1;

    assign take0       = req0_valid_i & req0_ready_o;
    assign take1       = req1_valid_i & req1_ready_o;
    assign owner_ready = owner ? rsp1_ready_i : rsp0_ready_i;

    assign rsp0_valid_o = (state == DONE) & ~owner;
    assign rsp1_valid_o = (state == DONE) &  owner;
    assign busy_o       = (state != IDLE);
    assign result_o     = result;
    assign mult_a_o     = op_a;
    assign mult_b_o     = op_b;

    // Transaction sequencer: IDLE -> WAIT (LAT cycles) -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (take0) begin
                        op_a       <= req0_a_i;
                        op_b       <= req0_b_i;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT;
                    end else if (take1) begin
                        op_a       <= req1_a_i;
                        op_b       <= req1_b_i;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        cnt        <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAT_M1) begin
                        result <= mult_p_i;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (owner_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_koa_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_koa_share_ctrl
//  Description : Directed self-checking bench for koa_share_ctrl (SW=24,
//                LAT=2) with an ideal combinational multiplier model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_koa_share_ctrl;

    localparam int SW  = 24;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid_i, req1_valid_i;
    logic            req0_ready_o, req1_ready_o;
    logic [SW-1:0]   req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic            rsp0_valid_o, rsp1_valid_o;
    logic            rsp0_ready_i, rsp1_ready_i;
    logic [2*SW-1:0] result_o;
    logic [SW-1:0]   mult_a_o, mult_b_o;
    logic [2*SW-1:0] mult_p_i;
    logic            busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    koa_share_ctrl #(.SW(SW), .LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp0_ready_i (rsp0_ready_i),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp1_ready_i (rsp1_ready_i),
        .result_o     (result_o),
        .mult_a_o     (mult_a_o),
        .mult_b_o     (mult_b_o),
        .mult_p_i     (mult_p_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Ideal multiplier: the product is always valid for the presented operands.
    assign mult_p_i = {{SW{1'b0}}, mult_a_o} * {{SW{1'b0}}, mult_b_o};

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup();
        rst = 1'b1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        req0_a_i = '0; req0_b_i = '0; req1_a_i = '0; req1_b_i = '0;
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
        tick(); tick();
        n_tests++;
        if ({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, busy_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL powerup_ctl got=%b exp=00000",
                     {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, busy_o});
        end
        n_tests++;
        if ({result_o, mult_a_o, mult_b_o} !== '0) begin
            n_fail++;
            $display("FAIL powerup_data result=%h a=%h b=%h exp=0", result_o, mult_a_o, mult_b_o);
        end
        rst = 1'b0;
        #1;
        // Tie right after reset: req0 must win.
        n_tests++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL powerup_tie got=%b exp=10", {req0_ready_o, req1_ready_o});
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0_valid_i = 1'b1; req0_a_i = 24'h000003; req0_b_i = 24'h000005;
        #1;
        n_tests++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_grant got=%b exp=10", {req0_ready_o, req1_ready_o});
        end
        tick();                                // transfer edge E
        req0_valid_i = 1'b0;
        n_tests++;
        if ({busy_o, req0_ready_o, rsp0_valid_o} !== 3'b100 || mult_a_o !== 24'h3 || mult_b_o !== 24'h5) begin
            n_fail++;
            $display("FAIL single_wait busy/rdy/vld=%b a=%h b=%h exp=100 3 5",
                     {busy_o, req0_ready_o, rsp0_valid_o}, mult_a_o, mult_b_o);
        end
        tick();                                // E+1
        n_tests++;
        if (rsp0_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid got=%b exp=0", rsp0_valid_o);
        end
        tick();                                // E+2
        n_tests++;
        if ({rsp0_valid_o, rsp1_valid_o} !== 2'b10 || result_o !== 48'h00000000000F) begin
            n_fail++;
            $display("FAIL single_done vld=%b result=%h exp=10 00000000000f",
                     {rsp0_valid_o, rsp1_valid_o}, result_o);
        end
        // A non-owner consume must be ignored.
        rsp1_ready_i = 1'b1;
        tick();
        rsp1_ready_i = 1'b0;
        n_tests++;
        if (rsp0_valid_o !== 1'b1 || result_o !== 48'hF || mult_a_o !== 24'h3) begin
            n_fail++;
            $display("FAIL single_nonowner vld=%b result=%h a=%h exp=1 f 3", rsp0_valid_o, result_o, mult_a_o);
        end
        rsp0_ready_i = 1'b1;
        tick();
        rsp0_ready_i = 1'b0;
        n_tests++;
        if ({busy_o, rsp0_valid_o} !== 2'b00 || result_o !== 48'hF) begin
            n_fail++;
            $display("FAIL single_release busy/vld=%b result=%h exp=00 f", {busy_o, rsp0_valid_o}, result_o);
        end
    endtask

    task automatic test_reset();
        req0_valid_i = 1'b1; req0_a_i = 24'h000005; req0_b_i = 24'h000005;
        tick(); req0_valid_i = 1'b0;
        tick(); tick();
        n_tests++;
        if (rsp0_valid_o !== 1'b1 || result_o !== 48'd25) begin
            n_fail++;
            $display("FAIL reset_pre vld=%b result=%h exp=1 19", rsp0_valid_o, result_o);
        end
        req0_valid_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, busy_o} !== 5'b0 ||
            {result_o, mult_a_o, mult_b_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid ctl=%b result=%h a=%h b=%h exp=all 0",
                     {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, busy_o},
                     result_o, mult_a_o, mult_b_o);
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (req0_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release rdy=%b busy=%b exp=1 0", req0_ready_o, busy_o);
        end
        req0_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        logic [47:0] exp_res;
        logic        exp_own;
        rst = 1'b1;
        req0_valid_i = 1'b1; req0_a_i = 24'h000002; req0_b_i = 24'h000007;
        req1_valid_i = 1'b1; req1_a_i = 24'h000010; req1_b_i = 24'h000010;
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_own = k[0];
            exp_res = exp_own ? 48'h000000000100 : 48'h00000000000E;
            n_tests++;
            if ({req0_ready_o, req1_ready_o} !== {~exp_own, exp_own}) begin
                n_fail++;
                $display("FAIL tie_grant%0d got=%b exp=%b", k, {req0_ready_o, req1_ready_o}, {~exp_own, exp_own});
            end
            tick(); tick(); tick();
            n_tests++;
            if ({rsp0_valid_o, rsp1_valid_o} !== {~exp_own, exp_own} || result_o !== exp_res) begin
                n_fail++;
                $display("FAIL tie_done%0d vld=%b result=%h exp=%b %h",
                         k, {rsp0_valid_o, rsp1_valid_o}, result_o, {~exp_own, exp_own}, exp_res);
            end
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_max();
        req0_valid_i = 1'b1; req0_a_i = 24'hFFFFFF; req0_b_i = 24'hFFFFFF;
        tick(); req0_valid_i = 1'b0;
        tick(); tick();
        n_tests++;
        if (rsp0_valid_o !== 1'b1 || result_o !== 48'hFFFFFE000001) begin
            n_fail++;
            $display("FAIL max_operands vld=%b result=%h exp=1 fffffe000001", rsp0_valid_o, result_o);
        end
        rsp0_ready_i = 1'b1;
        tick();
        rsp0_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        req0_valid_i = 1'b1; req0_a_i = 24'h000123; req0_b_i = 24'h000456;
        tick(); req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_a_i = 24'h000021; req1_b_i = 24'h000003;
        #1;
        n_tests++;
        if (req1_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_wait_ready got=%b exp=0", req1_ready_o);
        end
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (rsp0_valid_o !== 1'b1 || result_o !== 48'h4EDC2 || req1_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d vld=%b result=%h rdy1=%b exp=1 4edc2 0",
                         k, rsp0_valid_o, result_o, req1_ready_o);
            end
            tick();
        end
        rsp0_ready_i = 1'b1;
        #1;
        n_tests++;
        if (req1_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done_ready got=%b exp=0", req1_ready_o);
        end
        tick();
        rsp0_ready_i = 1'b0;
        #1;
        n_tests++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_idle_grant got=%b exp=01", {req0_ready_o, req1_ready_o});
        end
        tick(); req1_valid_i = 1'b0;
        tick(); tick();
        n_tests++;
        if ({rsp0_valid_o, rsp1_valid_o} !== 2'b01 || result_o !== 48'h63) begin
            n_fail++;
            $display("FAIL bp_req1_done vld=%b result=%h exp=01 63", {rsp0_valid_o, rsp1_valid_o}, result_o);
        end
        rsp1_ready_i = 1'b1;
        tick();
        rsp1_ready_i = 1'b0;
    endtask

    task automatic test_reset_wait();
        req0_valid_i = 1'b1; req0_a_i = 24'h000009; req0_b_i = 24'h000009;
        tick(); req0_valid_i = 1'b0;
        tick();                                // second WAIT cycle
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstwait_drop got=%b exp=000", {busy_o, rsp0_valid_o, rsp1_valid_o});
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL rstwait_idle%0d got=%b exp=000", k, {busy_o, rsp0_valid_o, rsp1_valid_o});
            end
        end
        req1_valid_i = 1'b1; req1_a_i = 24'h001234; req1_b_i = 24'h000010;
        #1;
        n_tests++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstwait_grant got=%b exp=01", {req0_ready_o, req1_ready_o});
        end
        tick(); req1_valid_i = 1'b0;
        tick(); tick();
        n_tests++;
        if ({rsp0_valid_o, rsp1_valid_o} !== 2'b01 || result_o !== 48'h12340) begin
            n_fail++;
            $display("FAIL rstwait_done vld=%b result=%h exp=01 12340", {rsp0_valid_o, rsp1_valid_o}, result_o);
        end
        rsp1_ready_i = 1'b1;
        tick();
        rsp1_ready_i = 1'b0;
    endtask

    initial begin
        test_powerup();
        test_single();
        test_reset();
        test_tie();
        test_max();
        test_backpressure();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
